inflight_addr_tracker: RTL

- Parametrised successor of the in-flight flow feature address store.
- Holds forward and reverse feature-address pairs for flows that have reached threshold and are being processed by the RV core / DL engine.
- Each release request from the external module pops the oldest pair and presents it to the tracker for freeing.
- Adds full/empty/occupancy status, overflow/underflow protection with sticky errors, flush, and output valid exactly aligned with output data.

---
 rtl/inflight_addr_pkg.sv | 18 +
 rtl/addr_delay_pipe.sv | 38 +++
 rtl/inflight_addr_tracker.sv | 113 +++++++++++
 3 files changed

// File: rtl/inflight_addr_pkg.sv
// Shared constants and types for the in-flight feature address tracker.
package inflight_addr_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DEPTH  = 64;

    // Forward/reverse feature address pair at the default address width
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] r_addr;
        logic [DEF_ADDR_W-1:0] addr;
    } addr_pair_t;

    // Bits needed to hold an occupancy of 0..depth inclusive
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/addr_delay_pipe.sv
// Fixed-latency shift pipe carrying a valid bit and its data together.
// Data stages only advance behind a valid, so the last stage holds the
// most recent delivered pair while out_v is low.
module addr_delay_pipe #(
    parameter int W   = 24,
    parameter int LAT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         kill,
    input  logic         in_v,
    input  logic [W-1:0] in_d,
    output logic         out_v,
    output logic [W-1:0] out_d
);

    logic [LAT:1]        vld_pipe;
    logic [LAT:1][W-1:0] dat_pipe;

    // Advance valids every cycle (kill empties them); move data only behind a valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= in_v & ~kill;
            if (in_v && !kill) dat_pipe[1] <= in_d;
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1] & ~kill;
                if (vld_pipe[i-1] && !kill) dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign out_v = vld_pipe[LAT];
    assign out_d = dat_pipe[LAT];

endmodule

// File: rtl/inflight_addr_tracker.sv
// Circular store of forward/reverse feature address pairs for flows in
// flight; each release pops the oldest pair and delivers it OUT_LAT cycles
// later for freeing. Provides occupancy flags and sticky misuse errors.
module inflight_addr_tracker
    import inflight_addr_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int OUT_LAT  = 3,
    parameter int AFULL_TH = 56
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic [ADDR_W-1:0]          push_r_addr,
    input  logic                       pop,
    input  logic                       flush,
    input  logic                       err_clr,
    output logic [ADDR_W-1:0]          free_addr,
    output logic [ADDR_W-1:0]          free_r_addr,
    output logic                       free_v,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       afull,
    output logic                       ovf_err,
    output logic                       udf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

    typedef struct packed {
        logic [ADDR_W-1:0] r_addr;
        logic [ADDR_W-1:0] addr;
    } pair_t;

    pair_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_acc, pop_acc, ovf_evt, udf_evt;
    logic [CW-1:0] count_nxt;
    pair_t         rd_pair, out_pair;

    // Accept decisions and next occupancy; flush swallows that cycle's push/pop
    always_comb begin
        pop_acc   = pop & ~empty & ~flush;
        // A pop in the same cycle frees a slot, so a full store still accepts
        push_acc  = push & (~full | pop_acc) & ~flush;
        ovf_evt   = push & full & ~pop_acc & ~flush;
        udf_evt   = pop & empty & ~flush;
        count_nxt = count;
        if (flush)                      count_nxt = '0;
        else if (push_acc && !pop_acc)  count_nxt = count + CW'(1);
        else if (pop_acc && !push_acc)  count_nxt = count - CW'(1);
    end

    assign rd_pair = mem[rd_ptr];

    // Pair storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr] <= '{r_addr: push_r_addr, addr: push_addr};
    end

    // Pointers, occupancy flags and sticky errors (a new event beats err_clr)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            afull   <= 1'b0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_acc) wr_ptr <= wr_ptr + AW'(1);
                if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_C);
            empty <= (count_nxt == '0);
            afull <= (count_nxt >= AFULL_C);
            if (ovf_evt)      ovf_err <= 1'b1;
            else if (err_clr) ovf_err <= 1'b0;
            if (udf_evt)      udf_err <= 1'b1;
            else if (err_clr) udf_err <= 1'b0;
        end
    end

    addr_delay_pipe #(
        .W   (2*ADDR_W),
        .LAT (OUT_LAT)
    ) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .kill  (flush),
        .in_v  (pop_acc),
        .in_d  (rd_pair),
        .out_v (free_v),
        .out_d (out_pair)
    );

    assign free_addr   = out_pair.addr;
    assign free_r_addr = out_pair.r_addr;

endmodule
